// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu : 16-bit execute-stage ALU of the 16-bit RISC core.
// Applies the 4-bit opcode to A/B combinationally. The result is registered
// on every rising clock edge, so the output appears with one cycle of latency.
//
// Optional feature macro: ALU_FLAGS_EN
//   defined   -> a 'flags' output {Z,N,C,V} is registered alongside 'ans'
//   undefined -> there is no 'flags' port and no flag logic
//
// Opcode note: NOR (0xC) returns ~(A|B). For A=0x8010, B=0x0008 that is
// 16'h7FE7.
// ---------------------------------------------------------------------------
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [3:0]  op,
`ifdef ALU_FLAGS_EN
  output logic [3:0]  flags,
`endif
  output logic [15:0] ans
);

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_NOT   = 4'h5;
  localparam logic [3:0] OP_SLL   = 4'h6;
  localparam logic [3:0] OP_SRL   = 4'h7;
  localparam logic [3:0] OP_SRA   = 4'h8;
  localparam logic [3:0] OP_ROL   = 4'h9;
  localparam logic [3:0] OP_ROR   = 4'hA;
  localparam logic [3:0] OP_NAND  = 4'hB;
  localparam logic [3:0] OP_NOR   = 4'hC;
  localparam logic [3:0] OP_SLT   = 4'hD;
  localparam logic [3:0] OP_SLTU  = 4'hE;
  localparam logic [3:0] OP_PASSB = 4'hF;

  // Only B[3:0] is the shift/rotate amount; the upper bits of B are ignored.
  logic [3:0]  shamt_s;
  // The complementary amount (16 - n) is 5 bits wide. When n is 0 it becomes
  // 16, which shifts every bit out, so a zero rotate returns A unchanged.
  logic [4:0]  shamt_inv_s;
  logic [15:0] rol_s;
  logic [15:0] ror_s;
  logic [15:0] sra_s;
  logic [15:0] ans_d;
  logic [15:0] ans_q;

`ifdef ALU_FLAGS_EN
  // Adder and subtractor are widened to 17 bits so the carry/borrow is visible.
  logic [16:0] sum_s;
  logic [16:0] diff_s;
  logic        carry_d;
  logic        ovf_d;
  logic [3:0]  flags_d;
  logic [3:0]  flags_q;

  assign sum_s  = {1'b0, A} + {1'b0, B};
  assign diff_s = {1'b0, A} - {1'b0, B};
`else
  logic [15:0] sum_s;
  logic [15:0] diff_s;

  assign sum_s  = A + B;
  assign diff_s = A - B;
`endif

  assign shamt_s     = B[3:0];
  assign shamt_inv_s = 5'd16 - {1'b0, shamt_s};
  assign rol_s       = (A << shamt_s) | (A >> shamt_inv_s);
  assign ror_s       = (A >> shamt_s) | (A << shamt_inv_s);
  assign sra_s       = $signed(A) >>> shamt_s;

  // Select the result for the current opcode.
  always_comb begin
    ans_d = 16'h0000;
    case (op)
      OP_ADD:   ans_d = sum_s[15:0];
      OP_SUB:   ans_d = diff_s[15:0];
      OP_AND:   ans_d = A & B;
      OP_OR:    ans_d = A | B;
      OP_XOR:   ans_d = A ^ B;
      OP_NOT:   ans_d = ~A;
      OP_SLL:   ans_d = A << shamt_s;
      OP_SRL:   ans_d = A >> shamt_s;
      OP_SRA:   ans_d = sra_s;
      OP_ROL:   ans_d = rol_s;
      OP_ROR:   ans_d = ror_s;
      OP_NAND:  ans_d = ~(A & B);
      OP_NOR:   ans_d = ~(A | B);
      OP_SLT:   ans_d = ($signed(A) < $signed(B)) ? 16'h0001 : 16'h0000;
      OP_SLTU:  ans_d = (A < B) ? 16'h0001 : 16'h0000;
      OP_PASSB: ans_d = B;
      default:  ans_d = 16'h0000;
    endcase
  end

  // Result register; the asynchronous reset clears it at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ans_q <= 16'h0000;
    end else begin
      ans_q <= ans_d;
    end
  end

  assign ans = ans_q;

`ifdef ALU_FLAGS_EN
  // Carry and overflow are defined only for ADD and SUB. C on SUB means "no borrow".
  always_comb begin
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (op)
      OP_ADD: begin
        carry_d = sum_s[16];
        ovf_d   = (A[15] == B[15]) && (sum_s[15] != A[15]);
      end
      OP_SUB: begin
        carry_d = ~diff_s[16];
        ovf_d   = (A[15] != B[15]) && (diff_s[15] != A[15]);
      end
      default: begin
        carry_d = 1'b0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  // Pack the next flag value as {Z,N,C,V}.
  always_comb begin
    flags_d = {(ans_d == 16'h0000), ans_d[15], carry_d, ovf_d};
  end

  // Flag register, kept in step with the result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;
`endif

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu : directed self-checking bench for alu.
// Expected values are hand-computed constants. The flag checks are compiled
// only when ALU_FLAGS_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  op;
  logic [15:0] ans;
`ifdef ALU_FLAGS_EN
  logic [3:0]  flags;
`endif

  int n_checks;
  int n_fails;

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .op    (op),
`ifdef ALU_FLAGS_EN
    .flags (flags),
`endif
    .ans   (ans)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value is wrong.
  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one operation at the falling edge. Sample just after the next
  // rising edge, which gives one operation per cycle.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_ans,
                        input logic [3:0] exp_flags);
    @(negedge clk);
    op = o;
    A  = a;
    B  = b;
    @(posedge clk);
    #1;
    check_val(tag, ans, exp_ans);
`ifdef ALU_FLAGS_EN
    check_val({tag, "_flags"}, {12'h000, flags}, {12'h000, exp_flags});
`else
    if (exp_flags > 4'd15) $display("unexpected flag width");
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b0;
    A  = 16'h0000;
    B  = 16'h0000;
    op = 4'h0;
    #1;
    check_val("reset_ans", ans, 16'h0000);
`ifdef ALU_FLAGS_EN
    check_val("reset_flags", {12'h000, flags}, 16'h0000);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // The first edge after reset is released captures the current inputs.
    run_op("first_capture", 4'h3, 16'h1200, 16'h0034, 16'h1234, 4'b0000);

    // Sweep all sixteen opcodes with A=0x8010, B=0x0008.
    run_op("add",   4'h0, 16'h8010, 16'h0008, 16'h8018, 4'b0100);
    run_op("sub",   4'h1, 16'h8010, 16'h0008, 16'h8008, 4'b0110);
    run_op("and",   4'h2, 16'h8010, 16'h0008, 16'h0000, 4'b1000);
    run_op("or",    4'h3, 16'h8010, 16'h0008, 16'h8018, 4'b0100);
    run_op("xor",   4'h4, 16'h8010, 16'h0008, 16'h8018, 4'b0100);
    run_op("not",   4'h5, 16'h8010, 16'h0008, 16'h7FEF, 4'b0000);
    run_op("sll",   4'h6, 16'h8010, 16'h0008, 16'h1000, 4'b0000);
    run_op("srl",   4'h7, 16'h8010, 16'h0008, 16'h0080, 4'b0000);
    run_op("sra",   4'h8, 16'h8010, 16'h0008, 16'hFF80, 4'b0100);
    run_op("rol",   4'h9, 16'h8010, 16'h0008, 16'h1080, 4'b0000);
    run_op("ror",   4'hA, 16'h8010, 16'h0008, 16'h1080, 4'b0000);
    run_op("nand",  4'hB, 16'h8010, 16'h0008, 16'hFFFF, 4'b0100);
    run_op("nor",   4'hC, 16'h8010, 16'h0008, 16'h7FE7, 4'b0000);
    run_op("slt",   4'hD, 16'h8010, 16'h0008, 16'h0001, 4'b0000);
    run_op("sltu",  4'hE, 16'h8010, 16'h0008, 16'h0000, 4'b1000);
    run_op("passb", 4'hF, 16'h8010, 16'h0008, 16'h0008, 4'b0000);

    // Arithmetic boundary cases.
    run_op("add_carry", 4'h0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010);
    run_op("add_ovf",   4'h0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
    run_op("sub_borrow",4'h1, 16'h0000, 16'h0001, 16'hFFFF, 4'b0100);
    run_op("sub_ovf",   4'h1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011);

    // A shift amount of zero (B=0x0010, so B[3:0]=0) must return A unchanged.
    run_op("sll_amt0", 4'h6, 16'hA5C3, 16'h0010, 16'hA5C3, 4'b0100);
    run_op("sra_amt0", 4'h8, 16'hA5C3, 16'h0010, 16'hA5C3, 4'b0100);
    run_op("rol_amt0", 4'h9, 16'hA5C3, 16'h0010, 16'hA5C3, 4'b0100);
    run_op("sra_15",   4'h8, 16'h8000, 16'h000F, 16'hFFFF, 4'b0100);

    // Further shift, rotate and compare patterns.
    run_op("rol_1",    4'h9, 16'h8001, 16'hFFF1, 16'h0003, 4'b0000);
    run_op("ror_4",    4'hA, 16'h8001, 16'h0004, 16'h1800, 4'b0000);
    run_op("sra_pos",  4'h8, 16'h7F00, 16'h0004, 16'h07F0, 4'b0000);
    run_op("slt_neg",  4'hD, 16'h0005, 16'hFFFF, 16'h0000, 4'b1000);
    run_op("sltu_big", 4'hE, 16'h0005, 16'hFFFF, 16'h0001, 4'b0000);
    run_op("slt_eq",   4'hD, 16'h1234, 16'h1234, 16'h0000, 4'b1000);

    // Changing the inputs between edges must leave the output unchanged.
    run_op("hold_pre", 4'h0, 16'h0100, 16'h0023, 16'h0123, 4'b0000);
    #1;
    op = 4'hF;
    B  = 16'hBEEF;
    @(negedge clk);
    check_val("hold_mid", ans, 16'h0123);
    @(posedge clk);
    #1;
    check_val("hold_next", ans, 16'hBEEF);

    // Assert reset in the middle of a cycle while ans is nonzero. The clear
    // must not wait for a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_reset_ans", ans, 16'h0000);
`ifdef ALU_FLAGS_EN
    check_val("async_reset_flags", {12'h000, flags}, 16'h0000);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_reset", 4'h4, 16'h00FF, 16'h0F0F, 16'h0FF0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
